mux2_stream_arbiter: RTL and testbench
======================================

# mux2_stream_arbiter

Two-channel buffered stream arbiter that sits directly upstream of the 8-bit 2:1 multiplexer. Each producer writes into its own small FIFO with a valid/ready handshake. A round-robin arbiter picks one non-empty channel per transfer, registers that channel's word onto the matching mux leg, and drives the mux select. It qualifies the mux output with a valid/ready handshake toward the consumer.

## Interface
Parameters:
- DATA_W, 8, width of each channel and of each mux leg
- FIFO_DEPTH, 2, entries per channel FIFO; power of two, minimum 2

Ports:
- clk_i  input  1  single clock; all state updates on rising edge
- rst_i  input  1  reset, synchronous, active-high
- a_data_i  input  DATA_W  channel A word
- a_valid_i  input  1  channel A word present
- a_ready_o  output  1  channel A FIFO can accept
- b_data_i  input  DATA_W  channel B word
- b_valid_i  input  1  channel B word present
- b_ready_o  output  1  channel B FIFO can accept
- a_o  output  DATA_W  registered leg A, to mux a_i
- b_o  output  DATA_W  registered leg B, to mux b_i
- sel_o  output  1  registered select, to mux sel_i; 0 = leg A, 1 = leg B
- out_valid_o  output  1  mux output y holds a valid word
- out_ready_i  input  1  consumer accepts the mux output

## Operation
- Push rule: a word enters a channel FIFO on a rising edge where that channel's valid and ready are both 1.
- Ready rule: a_ready_o is !full_A and b_ready_o is !full_B, combinational from FIFO state.
  - Both ready outputs are forced 0 while rst_i is high.
  - There is no push-through when full: a full FIFO refuses the push even if it pops in the same cycle.
- Load condition: load = (!out_valid_o || out_ready_i) && (!empty_A || !empty_B).
- Grant selection:
  - Only one FIFO non-empty: grant that channel.
  - Both non-empty: grant the channel opposite last_grant.
- On a load edge with grant A:
  - a_o gets the head of FIFO A; sel_o gets 0; FIFO A pops; last_grant gets A.
  - b_o holds its value.
  - Grant B is symmetric: b_o gets the head of FIFO B, sel_o gets 1, FIFO B pops, last_grant gets B, a_o holds.
- out_valid_o:
  - Set to 1 on any load edge.
  - Cleared when out_ready_i is 1 and no load occurs.
  - Otherwise holds.
- While out_valid_o is 1 and out_ready_i is 0, a_o, b_o and sel_o are frozen.
- Each FIFO is a circular buffer with read and write pointers one bit wider than log2(FIFO_DEPTH).
  - Full and empty are derived from the pointers.
  - Pointers wrap modulo 2*FIFO_DEPTH.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy is unchanged and order is preserved.
- Push into an empty FIFO: the word becomes eligible for grant at the next edge, not the same edge.

## Timing
- Reset values (after any edge with rst_i high):
  - FIFOs empty, both pointers 0.
  - a_o = 0, b_o = 0, sel_o = 0, out_valid_o = 0.
  - last_grant = B, so A wins the first contended grant.
- Reset asserted mid-transfer discards all buffered and presented words. No partial state survives.
- Latency: a word pushed at edge k appears on its leg with out_valid_o = 1 after edge k+1 (two-edge minimum).
- Throughput: one word per cycle while out_ready_i is held 1 and at least one FIFO is non-empty.
- With both FIFOs continuously non-empty and out_ready_i = 1, sel_o strictly alternates A, B, A, B.
- The mux is purely combinational, so the consumer sees y valid in the same cycle as out_valid_o.

## Configuration
- MUX2_ARB_STATS_EN defined adds two ports:
  - grant_cnt_a_o  output  16  number of grants to A
  - grant_cnt_b_o  output  16  number of grants to B
- Each counter increments on every load edge granting its channel and saturates at 0xFFFF.
- Both counters reset to 0.
- MUX2_ARB_STATS_EN undefined: the ports and counters are absent. Arbitration behaviour is identical in both builds.

## Test plan
- Reset, then one push on A of 0x5A at edge 1 -> after edge 2: a_o = 0x5A, sel_o = 0, out_valid_o = 1, b_o = 0.
- Both channels loaded with 0x11, 0x22 (A) and 0x33, 0x44 (B), out_ready_i = 1 -> output order 0x11, 0x33, 0x22, 0x44 with sel_o 0, 1, 0, 1.
- out_ready_i = 0 with A pushed every cycle, FIFO_DEPTH = 2 -> a_ready_o drops to 0 after 3 accepted words (2 buffered + 1 presented); outputs frozen; no word lost after releasing out_ready_i.
- Assert rst_i for one cycle while both FIFOs hold data and out_valid_o = 1 -> all outputs return to reset values, and the first word pushed afterwards is the first word out.
- Push and consume 10 words on B alone -> pointer wrap is handled; output order equals input order; sel_o stays 1; a_o stays 0.
- With MUX2_ARB_STATS_EN defined, drive 70000 grants to A -> grant_cnt_a_o = 0xFFFF, grant_cnt_b_o = 0.

Source files
------------

// File: rtl/mux2_stream_arbiter.sv
// mux2_stream_arbiter
// Two-channel buffered round-robin arbiter feeding an external 2:1 mux.
// Each channel has a small FIFO. The arbiter registers the granted word onto
// that channel's mux leg and drives the mux select. A valid/ready handshake
// qualifies the combinational mux output toward the consumer.
// Optional feature: define MUX2_ARB_STATS_EN to add saturating 16-bit grant
// counters per channel (grant_cnt_a_o / grant_cnt_b_o).

module mux2_stream_arbiter_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o
);
    // Pointers carry one extra wrap bit so full and empty can be told apart.
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wptr_q, wptr_d;
    logic [AW:0]       rptr_q, rptr_d;

    assign data_o  = mem_q[rptr_q[AW-1:0]];
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);

    // Advance each pointer by one on push/pop; wrap is the natural overflow.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_i) wptr_d = wptr_q + {{AW{1'b0}}, 1'b1};
        if (pop_i)  rptr_d = rptr_q + {{AW{1'b0}}, 1'b1};
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is never read while empty, so it needs no reset.
    always_ff @(posedge clk_i) begin
        if (push_i) mem_q[wptr_q[AW-1:0]] <= data_i;
    end
endmodule

module mux2_stream_arbiter #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [DATA_W-1:0] a_data_i,
    input  logic              a_valid_i,
    output logic              a_ready_o,
    input  logic [DATA_W-1:0] b_data_i,
    input  logic              b_valid_i,
    output logic              b_ready_o,
    output logic [DATA_W-1:0] a_o,
    output logic [DATA_W-1:0] b_o,
    output logic              sel_o,
    output logic              out_valid_o,
    input  logic              out_ready_i
`ifdef MUX2_ARB_STATS_EN
   ,output logic [15:0]       grant_cnt_a_o
   ,output logic [15:0]       grant_cnt_b_o
`endif
);
    typedef enum logic {CH_A = 1'b0, CH_B = 1'b1} channel_e;

    logic              full_a, empty_a, full_b, empty_b;
    logic [DATA_W-1:0] head_a, head_b;
    logic              push_a, push_b, pop_a, pop_b;
    logic              load, grant_b;

    logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
    logic              sel_q, sel_d;
    logic              out_valid_q, out_valid_d;
    channel_e          last_grant_q, last_grant_d;

    // A full FIFO refuses pushes even when it pops that cycle; reset blocks all.
    assign a_ready_o = !full_a && !rst_i;
    assign b_ready_o = !full_b && !rst_i;
    assign push_a    = a_valid_i && a_ready_o;
    assign push_b    = b_valid_i && b_ready_o;

    mux2_stream_arbiter_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_a (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_a),
        .data_i  (a_data_i),
        .pop_i   (pop_a),
        .data_o  (head_a),
        .full_o  (full_a),
        .empty_o (empty_a)
    );

    mux2_stream_arbiter_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_b (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push_b),
        .data_i  (b_data_i),
        .pop_i   (pop_b),
        .data_o  (head_b),
        .full_o  (full_b),
        .empty_o (empty_b)
    );

    // Load whenever the output slot is free or being consumed and a word waits;
    // on contention the channel that did not win last time is granted.
    always_comb begin
        load    = (!out_valid_q || out_ready_i) && (!empty_a || !empty_b);
        grant_b = !empty_b && (empty_a || (last_grant_q == CH_A));
        pop_a   = load && !grant_b;
        pop_b   = load && grant_b;
    end

    // Next-state for the presented legs, select, valid flag and grant history.
    always_comb begin
        a_d          = a_q;
        b_d          = b_q;
        sel_d        = sel_q;
        out_valid_d  = out_valid_q;
        last_grant_d = last_grant_q;
        if (load) begin
            out_valid_d = 1'b1;
            if (grant_b) begin
                b_d          = head_b;
                sel_d        = 1'b1;
                last_grant_d = CH_B;
            end else begin
                a_d          = head_a;
                sel_d        = 1'b0;
                last_grant_d = CH_A;
            end
        end else if (out_ready_i) begin
            out_valid_d = 1'b0;
        end
    end

    // Output registers; reset makes A win the first contended grant.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            a_q          <= '0;
            b_q          <= '0;
            sel_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            last_grant_q <= CH_B;
        end else begin
            a_q          <= a_d;
            b_q          <= b_d;
            sel_q        <= sel_d;
            out_valid_q  <= out_valid_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign a_o         = a_q;
    assign b_o         = b_q;
    assign sel_o       = sel_q;
    assign out_valid_o = out_valid_q;

`ifdef MUX2_ARB_STATS_EN
    logic [15:0] cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;

    // Count grants per channel, sticking at all-ones instead of wrapping.
    always_comb begin
        cnt_a_d = cnt_a_q;
        cnt_b_d = cnt_b_q;
        if (pop_a && (cnt_a_q != 16'hFFFF)) cnt_a_d = cnt_a_q + 16'd1;
        if (pop_b && (cnt_b_q != 16'hFFFF)) cnt_b_d = cnt_b_q + 16'd1;
    end

    // Grant counter registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_a_q <= '0;
            cnt_b_q <= '0;
        end else begin
            cnt_a_q <= cnt_a_d;
            cnt_b_q <= cnt_b_d;
        end
    end

    assign grant_cnt_a_o = cnt_a_q;
    assign grant_cnt_b_o = cnt_b_q;
`endif
endmodule

// File: tb/tb_mux2_stream_arbiter.sv
// Testbench for mux2_stream_arbiter: queue-based reference model, scoreboard
// of expected consumed words, and a monitor that checks every handshake.
// Define MUX2_ARB_STATS_EN to also exercise the grant counters.

module tb_mux2_stream_arbiter;
    localparam int DW = 8;
    localparam int D  = 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic [DW-1:0] a_data_i, b_data_i;
    logic          a_valid_i, b_valid_i, out_ready_i;
    logic          a_ready_o, b_ready_o, sel_o, out_valid_o;
    logic [DW-1:0] a_o, b_o;
`ifdef MUX2_ARB_STATS_EN
    logic [15:0]   grant_cnt_a_o, grant_cnt_b_o;
`endif

    mux2_stream_arbiter #(.DATA_W(DW), .FIFO_DEPTH(D)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .a_data_i    (a_data_i),
        .a_valid_i   (a_valid_i),
        .a_ready_o   (a_ready_o),
        .b_data_i    (b_data_i),
        .b_valid_i   (b_valid_i),
        .b_ready_o   (b_ready_o),
        .a_o         (a_o),
        .b_o         (b_o),
        .sel_o       (sel_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
`ifdef MUX2_ARB_STATS_EN
       ,.grant_cnt_a_o (grant_cnt_a_o)
       ,.grant_cnt_b_o (grant_cnt_b_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state: channel contents as queues plus presented word.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [8:0] expq[$];
    logic [7:0] obsq[$];
    logic       mLastB, mValid, mSel;
    logic [7:0] mA, mB;
    int         mCntA, mCntB;
    int         acceptA;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelStep(input logic av, input logic [7:0] ad, input logic bv,
                             input logic [7:0] bd, input logic ordy, input logic rst);
        logic accA, accB, ld, gB;
        if (rst) begin
            qa.delete(); qb.delete(); expq.delete();
            mLastB = 1'b1; mValid = 1'b0; mSel = 1'b0; mA = '0; mB = '0;
            mCntA = 0; mCntB = 0;
        end else begin
            accA = av && (qa.size() < D);
            accB = bv && (qb.size() < D);
            ld   = (!mValid || ordy) && (qa.size() > 0 || qb.size() > 0);
            if (ld) begin
                gB = (qa.size() > 0 && qb.size() > 0) ? !mLastB : (qb.size() > 0);
                if (gB) begin
                    mB = qb.pop_front(); mSel = 1'b1; mLastB = 1'b1;
                    expq.push_back({1'b1, mB});
                    if (mCntB < 65535) mCntB++;
                end else begin
                    mA = qa.pop_front(); mSel = 1'b0; mLastB = 1'b0;
                    expq.push_back({1'b0, mA});
                    if (mCntA < 65535) mCntA++;
                end
                mValid = 1'b1;
            end else if (ordy) begin
                mValid = 1'b0;
            end
            if (accA) qa.push_back(ad);
            if (accB) qb.push_back(bd);
        end
    endtask

    // One clock cycle: drive inputs, compare DUT state with the model, step model.
    task automatic applyStimulus(input logic av, input logic [7:0] ad, input logic bv,
                                 input logic [7:0] bd, input logic ordy, input logic rst);
        a_valid_i = av; a_data_i = ad; b_valid_i = bv; b_data_i = bd;
        out_ready_i = ordy; rst_i = rst;
        #1;
        checkOutput("a_o", a_o, mA);
        checkOutput("b_o", b_o, mB);
        checkOutput("sel_o", sel_o, mSel);
        checkOutput("out_valid_o", out_valid_o, mValid);
        checkOutput("a_ready_o", a_ready_o, !rst && (qa.size() < D));
        checkOutput("b_ready_o", b_ready_o, !rst && (qb.size() < D));
`ifdef MUX2_ARB_STATS_EN
        checkOutput("grant_cnt_a_o", grant_cnt_a_o, mCntA);
        checkOutput("grant_cnt_b_o", grant_cnt_b_o, mCntB);
`endif
        if (a_valid_i && a_ready_o) acceptA++;
        modelStep(av, ad, bv, bd, ordy, rst);
        @(posedge clk_i);
        #1;
    endtask

    // Monitor: every consumer handshake must match the oldest expected word.
    always @(negedge clk_i) begin
        logic [8:0] e;
        logic [7:0] y;
        if (rst_i === 1'b0 && out_valid_o === 1'b1 && out_ready_i === 1'b1) begin
            y = sel_o ? b_o : a_o;
            obsq.push_back(y);
            if (expq.size() == 0) begin
                checkOutput("unexpected handshake", {23'd0, sel_o, y}, 32'h1FF00);
            end else begin
                e = expq.pop_front();
                checkOutput("handshake sel", sel_o, e[8]);
                checkOutput("handshake y", y, e[7:0]);
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        logic [7:0] exp4 [4];
        rst_i = 1'b1; a_valid_i = 0; b_valid_i = 0; a_data_i = 0; b_data_i = 0;
        out_ready_i = 0; acceptA = 0;
        repeat (2) @(posedge clk_i);
        #1;
        modelStep(0, 0, 0, 0, 0, 1);

        // Reset state, then a single word on A.
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 1);
        applyStimulus(1, 8'h5A, 0, 8'h00, 0, 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 0);
        checkOutput("tp1 a_o", a_o, 8'h5A);
        checkOutput("tp1 sel_o", sel_o, 0);
        checkOutput("tp1 out_valid_o", out_valid_o, 1);
        checkOutput("tp1 b_o", b_o, 0);
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 0);

        // Contended order from reset: A, B, A, B.
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 1);
        obsq.delete();
        applyStimulus(1, 8'h11, 1, 8'h33, 1, 0);
        applyStimulus(1, 8'h22, 1, 8'h44, 1, 0);
        repeat (5) applyStimulus(0, 8'h00, 0, 8'h00, 1, 0);
        exp4 = '{8'h11, 8'h33, 8'h22, 8'h44};
        checkOutput("tp2 count", obsq.size(), 4);
        for (int i = 0; i < 4 && i < obsq.size(); i++)
            checkOutput("tp2 order", obsq[i], exp4[i]);

        // Stall with A pushed every cycle: only three words accepted.
        applyStimulus(0, 8'h00, 0, 8'h00, 0, 1);
        acceptA = 0;
        for (int i = 0; i < 6; i++) applyStimulus(1, 8'hA0 + 8'(i), 0, 8'h00, 0, 0);
        checkOutput("tp3 accepted", acceptA, 3);
        repeat (6) applyStimulus(0, 8'h00, 0, 8'h00, 1, 0);

        // Reset mid-transfer discards everything.
        applyStimulus(1, 8'hC1, 1, 8'hD1, 0, 0);
        applyStimulus(1, 8'hC2, 1, 8'hD2, 0, 0);
        applyStimulus(1, 8'hC3, 1, 8'hD3, 0, 1);
        checkOutput("tp4 out_valid_o", out_valid_o, 0);
        checkOutput("tp4 a_o", a_o, 0);
        obsq.delete();
        applyStimulus(0, 8'h00, 1, 8'h77, 1, 0);
        repeat (3) applyStimulus(0, 8'h00, 0, 8'h00, 1, 0);
        checkOutput("tp4 first word", (obsq.size() > 0) ? obsq[0] : 8'h00, 8'h77);

        // Ten words on B alone exercise pointer wrap.
        obsq.delete();
        for (int i = 0; i < 10; i++) applyStimulus(0, 8'h00, 1, 8'hB0 + 8'(i), 1, 0);
        repeat (4) applyStimulus(0, 8'h00, 0, 8'h00, 1, 0);
        checkOutput("tp5 count", obsq.size(), 10);
        for (int i = 0; i < 10 && i < obsq.size(); i++)
            checkOutput("tp5 order", obsq[i], 8'hB0 + 8'(i));

        // Randomised traffic with occasional resets.
        for (int i = 0; i < 2000; i++)
            applyStimulus($urandom_range(0, 1), 8'($urandom), $urandom_range(0, 1), 8'($urandom),
                          $urandom_range(0, 9) < 7, $urandom_range(0, 255) == 0);
        repeat (8) applyStimulus(0, 8'h00, 0, 8'h00, 1, 0);
        checkOutput("scoreboard drained", expq.size(), 0);

`ifdef MUX2_ARB_STATS_EN
        // Saturation of the A grant counter.
        applyStimulus(0, 8'h00, 0, 8'h00, 1, 1);
        for (int i = 0; i < 70002; i++) applyStimulus(1, 8'(i), 0, 8'h00, 1, 0);
        checkOutput("cnt_a saturated", grant_cnt_a_o, 16'hFFFF);
        checkOutput("cnt_b zero", grant_cnt_b_o, 16'h0000);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
